// File: rtl/ring_pkg.sv
// Shared types and constants for the ring rotate/swap shuffle element.
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_SWAP   = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/ring_xor_fold.sv
// Combinational XOR-fold of DEPTH packed WIDTH-bit entries into one WIDTH-bit word.
module ring_xor_fold #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]       o_fold
);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    o_fold = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_fold = o_fold ^ i_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/ring_rotate_swap.sv
// Register ring with burst rotate / pairwise-swap operations and a done pulse.
// Optional XOR-fold integrity checker enabled by defining RING_INTEGRITY_EN.
module ring_rotate_swap
  import ring_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [STEP_W-1:0]      steps,
  input  logic                   mode,
  input  logic                   dir,
  input  logic                   hold,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_W-1:0]      steps_left,
  output logic                   integrity_err
);

  logic [DEPTH-1:0][WIDTH-1:0] r_ring;
  logic [DEPTH-1:0][WIDTH-1:0] w_next;
  state_t                      r_state;
  logic                        r_mode;
  logic                        r_dir;
  logic [STEP_W-1:0]           r_steps_left;
  logic                        r_done;
  logic                        w_op;

  assign w_op = (r_state == RUN) && !hold;

  // Next ring contents are computed from the current snapshot only, so entries never see a half-updated neighbour.
  always_comb begin
    w_next = r_ring;
    if (w_op) begin
      if (r_mode == MODE_SWAP) begin
        for (int i = 0; i + 1 < DEPTH; i += 2) begin
          w_next[i]   = r_ring[i+1];
          w_next[i+1] = r_ring[i];
        end
      end else if (r_dir == DIR_UP) begin
        for (int i = 0; i < DEPTH; i++) begin
          w_next[(i+1) % DEPTH] = r_ring[i];
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          w_next[i] = r_ring[(i+1) % DEPTH];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all entries commit together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the ring storage is reset explicitly because its reset contents are visible on q.
      r_ring       <= '0;
      r_state      <= IDLE;
      r_mode       <= MODE_ROTATE;
      r_dir        <= DIR_UP;
      r_steps_left <= '0;
      r_done       <= 1'b0;
    end else begin
      r_ring <= w_next;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_ring <= load_data;
          end else if (start) begin
            r_mode <= mode;
            r_dir  <= dir;
            if (steps == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_steps_left <= steps;
              r_state      <= RUN;
            end
          end
        end
        RUN: begin
          if (!hold) begin
            r_steps_left <= r_steps_left - STEP_W'(1);
            if (r_steps_left == STEP_W'(1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign q          = r_ring;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign steps_left = r_steps_left;

`ifdef RING_INTEGRITY_EN
  logic [WIDTH-1:0] w_fold;
  logic [WIDTH-1:0] r_fold_ref;
  logic             r_integrity_err;

  // In IDLE without load, w_next equals the current ring, so one fold unit serves both latch and compare.
  ring_xor_fold #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fold (
    .i_data (w_next),
    .o_fold (w_fold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fold_ref      <= '0;
      r_integrity_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) && !load && start) begin
        r_fold_ref <= w_fold;
      end
      if ((r_state == RUN) && (w_fold != r_fold_ref)) begin
        r_integrity_err <= 1'b1;
      end
    end
  end

  assign integrity_err = r_integrity_err;
`else
  assign integrity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_rotate_swap.sv
// Self-checking bench for ring_rotate_swap: transaction-level model plus directed literal checks.
// Defining RING_INTEGRITY_EN also exercises the integrity checker with a forced fault.
module tb_ring_rotate_swap;
  import ring_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int STEP_W = 8;
  localparam int NW     = DEPTH * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [NW-1:0]     load_data;
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              mode;
  logic              dir;
  logic              hold;
  logic [NW-1:0]     q;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;
  logic              integrity_err;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  localparam logic [NW-1:0] ORIG = 32'h4433_2211;

  ring_rotate_swap #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .load_data     (load_data),
    .start         (start),
    .steps         (steps),
    .mode          (mode),
    .dir           (dir),
    .hold          (hold),
    .q             (q),
    .busy          (busy),
    .done          (done),
    .steps_left    (steps_left),
    .integrity_err (integrity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: contents = f(base snapshot, operations applied so far), no cycle-level state encoding.
  logic [DEPTH-1:0][WIDTH-1:0] m_base;
  int  m_applied, m_total;
  bit  m_run, m_done, m_mode, m_dir;

  function automatic logic [NW-1:0] exp_q();
    logic [DEPTH-1:0][WIDTH-1:0] r;
    int k;
    k = m_applied % DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_mode) begin
        r[i] = ((m_applied % 2 == 1) && ((i ^ 1) < DEPTH)) ? m_base[i ^ 1] : m_base[i];
      end else if (!m_dir) begin
        r[i] = m_base[((i - k) % DEPTH + DEPTH) % DEPTH];
      end else begin
        r[i] = m_base[(i + k) % DEPTH];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_base = '0; m_applied = 0; m_total = 0;
      m_run = 0; m_done = 0; m_mode = 0; m_dir = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (!hold) begin
        m_applied++;
        if (m_applied == m_total) begin
          m_run = 0; m_done = 1;
        end
      end
    end else if (load) begin
      m_base = load_data; m_applied = 0; m_total = 0;
    end else if (start) begin
      m_base = exp_q(); m_applied = 0; m_total = int'(steps);
      m_mode = mode; m_dir = dir;
      if (steps == 0) m_done = 1;
      else m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("q", q, exp_q());
      check("busy", busy, m_run || m_done);
      check("done", done, m_done);
      check("steps_left", steps_left, m_run ? (m_total - m_applied) : 0);
      check("integrity_err", integrity_err, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [NW-1:0] v);
    load = 1'b1; load_data = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input int s, input logic m, input logic d);
    start = 1'b1; steps = STEP_W'(s); mode = m; dir = d;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; ends at the negedge where done is high.
  task automatic wait_done(input int start_n, input int exp_n, input string name);
    int n;
    bit seen;
    n = start_n;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    check(name, seen ? n : -1, exp_n);
  endtask

`ifdef RING_INTEGRITY_EN
  logic [NW-1:0] fault_val;
`endif

  initial begin
    rst = 1'b1; load = 1'b0; load_data = '0; start = 1'b0;
    steps = '0; mode = 1'b0; dir = 1'b0; hold = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steps_left", steps_left, 0);
    check("rst_integ", integrity_err, 0);
    rst = 1'b0;
    check_en = 1'b1;
    tick();

    // One up-rotation
    do_load(ORIG);
    do_start(1, MODE_ROTATE, DIR_UP);
    wait_done(0, 1, "lat_rot1");
    check("rot_up1", q, 32'h3322_1144);
    tick();

    // One down-rotation
    do_load(ORIG);
    do_start(1, MODE_ROTATE, DIR_DOWN);
    wait_done(0, 1, "lat_rotdn1");
    check("rot_dn1", q, 32'h1144_3322);
    tick();

    // Full rotation with a two-cycle pause
    do_load(ORIG);
    do_start(4, MODE_ROTATE, DIR_DOWN);
    tick();
    hold = 1'b1;
    tick(); tick();
    hold = 1'b0;
    wait_done(3, 6, "lat_hold");
    check("rot_full", q, ORIG);
    tick();

    // Swap bursts
    do_load(ORIG);
    do_start(1, MODE_SWAP, DIR_UP);
    wait_done(0, 1, "lat_swap1");
    check("swap1", q, 32'h3344_1122);
    tick();
    do_start(2, MODE_SWAP, DIR_UP);
    wait_done(0, 2, "lat_swap2");
    check("swap2", q, 32'h3344_1122);
    tick();

    // Zero-step burst
    do_start(0, MODE_ROTATE, DIR_UP);
    wait_done(0, 0, "lat_zero");
    check("zero_q", q, 32'h3344_1122);
    tick();

    // load/start ignored while running
    do_load(ORIG);
    do_start(3, MODE_ROTATE, DIR_UP);
    load = 1'b1; load_data = 32'hDEAD_BEEF; start = 1'b1; steps = 8'd9;
    tick();
    load = 1'b0; start = 1'b0;
    wait_done(1, 3, "lat_blocked");
    check("blocked_q", q, 32'h1144_3322);
    tick();

    // load/start collision in IDLE
    load = 1'b1; load_data = 32'hA5C3_0F96; start = 1'b1; steps = 8'd2;
    tick();
    load = 1'b0; start = 1'b0;
    @(negedge clk);
    check("coll_busy", busy, 0);
    check("coll_q", q, 32'hA5C3_0F96);
    tick();

    // Reset in the middle of a burst
    do_start(5, MODE_ROTATE, DIR_UP);
    tick(); tick();
    @(negedge clk);
    check("mid_steps_left", steps_left, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_q", q, 0);
    check("midrst_busy", busy, 0);
    check("midrst_steps_left", steps_left, 0);
    check("midrst_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    tick();

`ifdef RING_INTEGRITY_EN
    // Normal bursts above left the flag clear; now corrupt an entry during a burst
    do_load(ORIG);
    do_start(4, MODE_ROTATE, DIR_UP);
    check_en = 1'b0;
    fault_val = dut.r_ring ^ 32'h0000_0100;
    force dut.r_ring = fault_val;
    tick();
    release dut.r_ring;
    @(negedge clk);
    check("integ_set", integrity_err, 1);
    wait_done(1, 4, "lat_integ");
    tick(); tick(); tick();
    @(negedge clk);
    check("integ_sticky", integrity_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("integ_cleared", integrity_err, 0);
    check_en = 1'b1;
    tick();
`endif

    tick();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
